// File: rtl/acq_seq_ctrl.sv
// acq_seq_ctrl: EMAT acquisition sequencer.
// One start command fires the transmitter N times at a fixed repetition period.
// It opens one ADC capture window per shot.
// It then waits for the result FIFO to fill and for the ARM to finish reading.
// It reports done on completion, or a sticky error if the read phase times out.
module acq_seq_ctrl #(
    parameter int PRF_DIV   = 64000,    // clocks between successive tx_fire rising edges
    parameter int REC_LEN   = 8192,     // capture-window length in clocks
    parameter int ADC_DELAY = 16,       // blanking between tx_fire falling and window start
    parameter int TIMEOUT   = 4000000   // max clocks spent waiting for the read-out
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic [2:0] i_burst_period,
    input  logic [9:0] i_pulse_period,
    input  logic       i_fifo_full,
    input  logic       i_arm_read_over,
    output logic       o_tx_fire,
    output logic       o_ad_data_valid,
    output logic [2:0] o_shot_idx,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_error,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FIRE    = 3'd1,
        S_DELAY   = 3'd2,
        S_ACQ     = 3'd3,
        S_GAP     = 3'd4,
        S_WAIT_RD = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    // Terminal counts, pre-computed so every compare is a plain 32-bit equality/magnitude.
    localparam logic [31:0] C_PRF_LAST = 32'(PRF_DIV - 1);
    localparam logic [31:0] C_REC_LAST = 32'(REC_LEN - 1);
    localparam logic [31:0] C_DLY_LAST = 32'(ADC_DELAY - 1);
    localparam logic [31:0] C_TO_LAST  = 32'(TIMEOUT - 1);

    state_t      r_state;
    logic [2:0]  r_n_last;       // latched N-1
    logic [9:0]  r_pw;           // latched pulse width, already forced to at least 1
    logic [31:0] r_prf_cnt;      // clocks since the current shot's tx_fire rising edge
    logic [31:0] r_phase_cnt;    // clocks spent in the current FIRE/DELAY/ACQ/WAIT_RD phase
    logic        r_full_seen;    // fifo_full observed since entering WAIT_RD

    logic [31:0] w_pw_last;
    logic        w_complete;

    assign w_pw_last  = {22'd0, r_pw} - 32'd1;
    // A read-over only counts once the FIFO has been (or is now) full.
    assign w_complete = i_arm_read_over & (r_full_seen | i_fifo_full);
    assign o_state    = r_state;

    // Sequencer FSM; every output is set on the same edge as the state it belongs to.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state         <= S_IDLE;
            r_n_last        <= 3'd0;
            r_pw            <= 10'd0;
            r_prf_cnt       <= 32'd0;
            r_phase_cnt     <= 32'd0;
            r_full_seen     <= 1'b0;
            o_tx_fire       <= 1'b0;
            o_ad_data_valid <= 1'b0;
            o_shot_idx      <= 3'd0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_error         <= 1'b0;
        end else begin
            o_done      <= 1'b0;
            r_prf_cnt   <= r_prf_cnt + 32'd1;
            r_phase_cnt <= r_phase_cnt + 32'd1;
            if (i_abort) begin
                r_state         <= S_IDLE;
                o_tx_fire       <= 1'b0;
                o_ad_data_valid <= 1'b0;
                o_busy          <= 1'b0;
                o_shot_idx      <= 3'd0;
                o_error         <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE, S_ERR: begin
                        if (i_start) begin
                            r_state     <= S_FIRE;
                            r_n_last    <= i_burst_period;
                            r_pw        <= (i_pulse_period == 10'd0) ? 10'd1 : i_pulse_period;
                            r_prf_cnt   <= 32'd0;
                            r_phase_cnt <= 32'd0;
                            o_error     <= 1'b0;
                            o_shot_idx  <= 3'd0;
                            o_tx_fire   <= 1'b1;
                            o_busy      <= 1'b1;
                        end
                    end
                    S_FIRE: begin
                        if (r_phase_cnt == w_pw_last) begin
                            o_tx_fire   <= 1'b0;
                            r_phase_cnt <= 32'd0;
                            if (ADC_DELAY == 0) begin
                                r_state         <= S_ACQ;
                                o_ad_data_valid <= 1'b1;
                            end else begin
                                r_state <= S_DELAY;
                            end
                        end
                    end
                    S_DELAY: begin
                        if (r_phase_cnt == C_DLY_LAST) begin
                            r_state         <= S_ACQ;
                            r_phase_cnt     <= 32'd0;
                            o_ad_data_valid <= 1'b1;
                        end
                    end
                    S_ACQ: begin
                        if (r_phase_cnt == C_REC_LAST) begin
                            o_ad_data_valid <= 1'b0;
                            r_phase_cnt     <= 32'd0;
                            if (o_shot_idx == r_n_last) begin
                                r_state     <= S_WAIT_RD;
                                r_full_seen <= 1'b0;
                            end else begin
                                r_state <= S_GAP;
                            end
                        end
                    end
                    S_GAP: begin
                        // A too-short PRF_DIV leaves GAP on its first clock and stretches the period.
                        if (r_prf_cnt >= C_PRF_LAST) begin
                            r_state     <= S_FIRE;
                            r_prf_cnt   <= 32'd0;
                            r_phase_cnt <= 32'd0;
                            o_shot_idx  <= o_shot_idx + 3'd1;
                            o_tx_fire   <= 1'b1;
                        end
                    end
                    S_WAIT_RD: begin
                        if (i_fifo_full) begin
                            r_full_seen <= 1'b1;
                        end
                        // Completion is tested first so it wins over a simultaneous timeout.
                        if (w_complete) begin
                            r_state    <= S_IDLE;
                            o_done     <= 1'b1;
                            o_busy     <= 1'b0;
                            o_shot_idx <= 3'd0;
                        end else if (r_phase_cnt == C_TO_LAST) begin
                            r_state <= S_ERR;
                            o_error <= 1'b1;
                            o_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state         <= S_IDLE;
                        o_tx_fire       <= 1'b0;
                        o_ad_data_valid <= 1'b0;
                        o_busy          <= 1'b0;
                        o_shot_idx      <= 3'd0;
                        o_error         <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acq_seq_ctrl.sv
// Bench for acq_seq_ctrl. Two instances share all inputs:
// dut0 uses a normal shot period (PRF_DIV=64); dut1 uses a too-short one (PRF_DIV=16).
// Each is checked every clock against a timeline model.
// Inside a burst, the model derives the expected phase from the elapsed time using the
// shot period max(PRF_DIV, width+delay+rec+1).
module tb_acq_seq_ctrl;

    localparam int D  = 4;
    localparam int L  = 16;
    localparam int TO = 100;

    localparam int M_IDLE = 0;
    localparam int M_SEQ  = 1;
    localparam int M_WAIT = 2;
    localparam int M_ERR  = 3;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_start, in_abort, in_ff, in_aro;
    logic [2:0] in_burst;
    logic [9:0] in_pulse;

    logic [1:0] tx, adv, busy, done, err;
    logic [2:0] shot [2];
    logic [2:0] st   [2];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state, one copy per instance.
    int m_mode [2];
    int m_t    [2];
    int m_n    [2];
    int m_w    [2];
    int m_wcnt [2];
    int m_shot [2];
    bit m_fs   [2];
    bit m_done [2];
    bit m_err  [2];

    // Observed-output tallies used by the directed burst checks.
    int adv_cnt [2];
    int gap_cnt [2];

    always #5 clk = ~clk;

    acq_seq_ctrl #(.PRF_DIV(64), .REC_LEN(L), .ADC_DELAY(D), .TIMEOUT(TO)) u_dut0 (
        .i_clk(clk), .i_reset_n(reset_n), .i_start(in_start), .i_abort(in_abort),
        .i_burst_period(in_burst), .i_pulse_period(in_pulse),
        .i_fifo_full(in_ff), .i_arm_read_over(in_aro),
        .o_tx_fire(tx[0]), .o_ad_data_valid(adv[0]), .o_shot_idx(shot[0]),
        .o_busy(busy[0]), .o_done(done[0]), .o_error(err[0]), .o_state(st[0])
    );

    acq_seq_ctrl #(.PRF_DIV(16), .REC_LEN(L), .ADC_DELAY(D), .TIMEOUT(TO)) u_dut1 (
        .i_clk(clk), .i_reset_n(reset_n), .i_start(in_start), .i_abort(in_abort),
        .i_burst_period(in_burst), .i_pulse_period(in_pulse),
        .i_fifo_full(in_ff), .i_arm_read_over(in_aro),
        .o_tx_fire(tx[1]), .o_ad_data_valid(adv[1]), .o_shot_idx(shot[1]),
        .o_busy(busy[1]), .o_done(done[1]), .o_error(err[1]), .o_state(st[1])
    );

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int period(input int d);
        int prf;
        prf = (d == 0) ? 64 : 16;
        return (prf > m_w[d] + D + L + 1) ? prf : (m_w[d] + D + L + 1);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = M_IDLE; m_t[d] = 0; m_n[d] = 1; m_w[d] = 1; m_wcnt[d] = 0;
            m_shot[d] = 0; m_fs[d] = 0; m_done[d] = 0; m_err[d] = 0;
        end
    endtask

    // Advance one instance's model by one clock edge using the inputs sampled at that edge.
    task automatic model_edge(input int d);
        m_done[d] = 0;
        if (in_abort) begin
            m_mode[d] = M_IDLE; m_err[d] = 0; m_shot[d] = 0;
        end else begin
            case (m_mode[d])
                M_IDLE, M_ERR: begin
                    if (in_start) begin
                        m_mode[d] = M_SEQ; m_t[d] = 0; m_n[d] = int'(in_burst) + 1;
                        m_w[d] = (in_pulse == 0) ? 1 : int'(in_pulse);
                        m_err[d] = 0; m_shot[d] = 0;
                    end
                end
                M_SEQ: begin
                    m_t[d]++;
                    if (m_t[d] == (m_n[d] - 1) * period(d) + m_w[d] + D + L) begin
                        m_mode[d] = M_WAIT; m_wcnt[d] = 0; m_fs[d] = 0; m_shot[d] = m_n[d] - 1;
                    end
                end
                M_WAIT: begin
                    m_wcnt[d]++;
                    if (in_aro && (m_fs[d] || in_ff)) begin
                        m_mode[d] = M_IDLE; m_done[d] = 1; m_shot[d] = 0;
                    end else if (m_wcnt[d] == TO) begin
                        m_mode[d] = M_ERR; m_err[d] = 1;
                    end
                    if (in_ff) m_fs[d] = 1;
                end
                default: m_mode[d] = M_IDLE;
            endcase
        end
    endtask

    task automatic check_dut(input int d);
        int p, u, e_tx, e_adv, e_busy, e_st, e_shot;
        e_tx = 0; e_adv = 0; e_busy = 0; e_st = 0; e_shot = m_shot[d];
        case (m_mode[d])
            M_SEQ: begin
                p = period(d);
                u = m_t[d] % p;
                e_shot = m_t[d] / p;
                e_busy = 1;
                if (u < m_w[d]) begin
                    e_st = 1; e_tx = 1;
                end else if (u < m_w[d] + D) begin
                    e_st = 2;
                end else if (u < m_w[d] + D + L) begin
                    e_st = 3; e_adv = 1;
                end else begin
                    e_st = 4;
                end
            end
            M_WAIT: begin e_st = 5; e_busy = 1; end
            M_ERR:  e_st = 6;
            default: e_st = 0;
        endcase
        chk_val($sformatf("dut%0d.tx_fire", d), 32'(tx[d]), e_tx);
        chk_val($sformatf("dut%0d.ad_data_valid", d), 32'(adv[d]), e_adv);
        chk_val($sformatf("dut%0d.shot_idx", d), 32'(shot[d]), e_shot);
        chk_val($sformatf("dut%0d.busy", d), 32'(busy[d]), e_busy);
        chk_val($sformatf("dut%0d.done", d), 32'(done[d]), 32'(m_done[d]));
        chk_val($sformatf("dut%0d.error", d), 32'(err[d]), 32'(m_err[d]));
        chk_val($sformatf("dut%0d.state", d), 32'(st[d]), e_st);
        adv_cnt[d] += int'(adv[d]);
        if (st[d] == 3'd4) gap_cnt[d]++;
    endtask

    // Inputs are already driven (at the falling edge); apply one rising edge, then check.
    task automatic step();
        @(posedge clk);
        for (int d = 0; d < 2; d++) model_edge(d);
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) check_dut(d);
    endtask

    // One command: start at c=0, single-clock pulses of the other inputs at the given offsets
    // (negative = never). Burst/pulse codes are randomised after c=0 to exercise latching.
    // The command is followed by an abort and an idle clock so both instances end in IDLE.
    task automatic run_scn(input int len, input int burst, input int pulse, input bit hold_start,
                           input int abort_at, input int ff_at, input int aro_at,
                           input int aro_early_at);
        for (int d = 0; d < 2; d++) begin adv_cnt[d] = 0; gap_cnt[d] = 0; end
        for (int c = 0; c < len; c++) begin
            in_start = (c == 0) || hold_start;
            in_abort = (c == abort_at);
            in_ff    = (c == ff_at);
            in_aro   = (c == aro_at) || (c == aro_early_at);
            in_burst = (c == 0) ? 3'(burst) : 3'($urandom_range(0, 7));
            in_pulse = (c == 0) ? 10'(pulse) : 10'($urandom_range(0, 1023));
            step();
        end
        in_start = 0; in_ff = 0; in_aro = 0; in_abort = 1;
        step();
        in_abort = 0;
        step();
    endtask

    initial begin
        reset_n = 0; in_start = 0; in_abort = 0; in_ff = 0; in_aro = 0;
        in_burst = 0; in_pulse = 0;
        model_reset();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) check_dut(d);
        reset_n = 1;
        step();

        // Single shot, width 3: full FIFO then read-over completes.
        run_scn(60, 0, 3, 0, -1, 30, 40, -1);
        // Burst of 3, width 2: three windows of 16 clocks; dut1 GAP lasts a single clock.
        run_scn(200, 2, 2, 0, -1, 160, 170, -1);
        chk_val("burst3_adv_dut0", 32'(adv_cnt[0]), 48);
        chk_val("burst3_adv_dut1", 32'(adv_cnt[1]), 48);
        chk_val("burst3_gap_dut0", 32'(gap_cnt[0]), 2 * (64 - 22));
        chk_val("burst3_gap_dut1", 32'(gap_cnt[1]), 2);
        // Read-over before FIFO full is ignored, then the timeout fires.
        // The trailing abort is dropped: the next command starts from ERR.
        for (int c = 0; c < 140; c++) begin
            in_start = (c == 0); in_burst = 0; in_pulse = 1;
            in_aro = (c == 30); in_ff = 0; in_abort = 0;
            step();
        end
        // Start from ERR; abort during shot 1's capture window.
        run_scn(120, 2, 2, 0, 64 + 2 + D + 5, -1, -1, -1);
        // Zero pulse width, with start held high throughout.
        run_scn(260, 1, 0, 1, -1, 120, 125, 60);

        // Randomised commands.
        for (int r = 0; r < 14; r++) begin
            run_scn(320, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                    1'($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 300)) : -1,
                    int'($urandom_range(0, 300)), int'($urandom_range(0, 319)),
                    int'($urandom_range(0, 319)));
        end

        // Asynchronous reset during FIRE: the gates must drop before the next rising edge.
        in_start = 1; in_burst = 0; in_pulse = 5;
        step();
        in_start = 0;
        step();
        #2 reset_n = 0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk_val($sformatf("async_rst.dut%0d.tx_fire", d), 32'(tx[d]), 0);
            chk_val($sformatf("async_rst.dut%0d.state", d), 32'(st[d]), 0);
        end
        model_reset();
        @(negedge clk);
        reset_n = 1;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
